mem_stage_ctrl: RTL and testbench
=================================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 15, max WAIT cycles before abort (range 1..255).
REQ-002 Parameter: CNT_W, default 16, width of stall-cycle statistics counter.
REQ-003 clk  in  1  clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 mem_read_i  in  1  EX/MEM control: current instruction loads.
REQ-006 mem_write_i  in  1  EX/MEM control: current instruction stores.
REQ-007 dmem_ready_i  in  1  data memory completion strobe.
REQ-008 dmem_rdata_i  in  32  data memory read data, valid when dmem_ready_i=1.
REQ-009 dmem_req_o  out  1  data memory request, held until completion or abort.
REQ-010 dmem_we_o  out  1  write qualifier, valid with dmem_req_o.
REQ-011 stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
REQ-012 wb_bubble_o  out  1  force MEM/WB WB-control to 2'b00 this cycle.
REQ-013 rdata_o  out  32  captured load data presented to MEM/WB.
REQ-014 timeout_o  out  1  sticky abort flag.
REQ-015 stall_cnt_o  out  CNT_W  saturating count of cycles with stall_o=1.

Function
REQ-016 FSM states SHALL be IDLE, REQ, WAIT, DONE, ERR; encoding free.
REQ-017 Access pending = mem_read_i | mem_write_i, sampled combinationally.
REQ-018 IDLE, no access: stall_o=0, wb_bubble_o=0, dmem_req_o=0; stay IDLE.
REQ-019 IDLE, access: stall_o=1, wb_bubble_o=1 same cycle (Mealy); next REQ.
REQ-020 REQ: dmem_req_o=1, stall_o=1, wb_bubble_o=1; ready -> DONE, else -> WAIT with wait counter cleared to 0.
REQ-021 WAIT: dmem_req_o=1, stall_o=1, wb_bubble_o=1; wait counter +1 per cycle; ready -> DONE (ready wins if same cycle as limit); counter==TIMEOUT-1 without ready -> ERR.
REQ-022 dmem_we_o SHALL equal mem_write_i while dmem_req_o=1, else 0; read and write both high -> write (dmem_we_o=1), no load data captured.
REQ-023 On ready in REQ/WAIT with a read, rdata_o SHALL load dmem_rdata_i at that edge; otherwise rdata_o holds.
REQ-024 DONE: stall_o=0, wb_bubble_o=0, dmem_req_o=0 for exactly one cycle; next IDLE unconditionally.
REQ-025 Minimum access latency: 3 cycles stalled-or-done from IDLE detect (IDLE, REQ, DONE) with ready in REQ.
REQ-026 ERR: dmem_req_o=0, stall_o=0, wb_bubble_o=1 (access dropped), timeout_o set; next IDLE.
REQ-027 timeout_o SHALL remain 1 until rst.
REQ-028 stall_cnt_o SHALL increment each cycle stall_o=1, saturate at all-ones, never wrap.
REQ-029 dmem_ready_i outside REQ/WAIT SHALL be ignored.

Reset
REQ-030 rst=1 at an edge: state IDLE, wait counter 0, rdata_o=0, timeout_o=0, stall_cnt_o=0, regardless of current state.
REQ-031 rst mid-access SHALL drop dmem_req_o next cycle without waiting for ready.
REQ-032 While rst=1, stall_o, wb_bubble_o, dmem_req_o, dmem_we_o SHALL be 0.

Verification
REQ-033 Load, ready in REQ, rdata=32'hDEADBEEF -> stall 2 cycles, DONE cycle rdata_o=DEADBEEF, stall_cnt_o=2.
REQ-034 Store, ready after 4 WAIT cycles -> dmem_we_o=1 throughout request, stall_o=1 for 6 cycles, rdata_o unchanged.
REQ-035 Load, never ready, TIMEOUT=15 -> ERR reached after 15 WAIT cycles, timeout_o=1 sticky, dmem_req_o drops.
REQ-036 Ready coincident with last WAIT cycle -> DONE, timeout_o stays 0.
REQ-037 rst asserted in WAIT -> next cycle IDLE, all outputs 0, stall_cnt_o=0.
REQ-038 Back-to-back loads -> DONE then immediate IDLE detect; CNT_W=4 run over 15 stall cycles -> stall_cnt_o=4'hF.

Source files
------------

// File: rtl/mem_stage_ctrl_if.sv
// Bundle between the MEM-stage controller, the EX/MEM control bits and the data memory.
// The master side is the controller; the slave side is pipeline plus memory.
interface mem_stage_ctrl_if #(
  parameter int CNT_W = 16
);
  logic              mem_read_i;
  logic              mem_write_i;
  logic              dmem_ready_i;
  logic [31:0]       dmem_rdata_i;
  logic              dmem_req_o;
  logic              dmem_we_o;
  logic              stall_o;
  logic              wb_bubble_o;
  logic [31:0]       rdata_o;
  logic              timeout_o;
  logic [CNT_W-1:0]  stall_cnt_o;

  modport master (
    input  mem_read_i, mem_write_i, dmem_ready_i, dmem_rdata_i,
    output dmem_req_o, dmem_we_o, stall_o, wb_bubble_o, rdata_o, timeout_o, stall_cnt_o
  );

  modport slave (
    output mem_read_i, mem_write_i, dmem_ready_i, dmem_rdata_i,
    input  dmem_req_o, dmem_we_o, stall_o, wb_bubble_o, rdata_o, timeout_o, stall_cnt_o
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: freezes the pipeline around a data-memory access,
// aborts on a bounded wait, and counts stall cycles.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  mem_stage_ctrl_if.master  bus
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, ERR} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t            state;
  logic [7:0]        wait_cnt;
  logic [31:0]       rdata;
  logic              timeout;
  logic [CNT_W-1:0]  stall_cnt;

  logic access;
  logic ready;
  logic req;
  logic we;
  logic stall;
  logic bubble;

  assign access = bus.mem_read_i | bus.mem_write_i;
  assign ready  = bus.dmem_ready_i;

  // Outputs decode from state plus live inputs: the IDLE detect is Mealy and
  // everything must drop in the same cycle rst is high.
  always_comb begin
    req    = 1'b0;
    stall  = 1'b0;
    bubble = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          stall  = access;
          bubble = access;
        end
        REQ, WAIT: begin
          req    = 1'b1;
          stall  = 1'b1;
          bubble = 1'b1;
        end
        ERR:     bubble = 1'b1;
        default: ;
      endcase
    end
    we = req & bus.mem_write_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      rdata     <= '0;
      timeout   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);

      // A store wins over a simultaneous load, so no data is captured then.
      if (req && ready && bus.mem_read_i && !bus.mem_write_i)
        rdata <= bus.dmem_rdata_i;

      case (state)
        IDLE: if (access) state <= REQ;
        REQ: begin
          if (ready) begin
            state <= DONE;
          end else begin
            state    <= WAIT;
            wait_cnt <= '0;
          end
        end
        WAIT: begin
          if (ready) begin
            state <= DONE;
          end else if (wait_cnt == WAIT_LAST) begin
            state   <= ERR;
            timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dmem_req_o  = req;
  assign bus.dmem_we_o   = we;
  assign bus.stall_o     = stall;
  assign bus.wb_bubble_o = bubble;
  assign bus.rdata_o     = rdata;
  assign bus.timeout_o   = timeout;
  assign bus.stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: two instances (long timeout / wide counter, short
// timeout / 4-bit counter) share stimulus and are compared to an access-age model.
module tb_mem_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd, wr, rdy;
  logic [31:0] rdat;

  always #5 clk = ~clk;

  mem_stage_ctrl_if #(.CNT_W(16)) bus0 ();
  mem_stage_ctrl_if #(.CNT_W(4))  bus1 ();

  assign bus0.mem_read_i   = rd;
  assign bus0.mem_write_i  = wr;
  assign bus0.dmem_ready_i = rdy;
  assign bus0.dmem_rdata_i = rdat;
  assign bus1.mem_read_i   = rd;
  assign bus1.mem_write_i  = wr;
  assign bus1.dmem_ready_i = rdy;
  assign bus1.dmem_rdata_i = rdat;

  mem_stage_ctrl #(.TIMEOUT(15), .CNT_W(16)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  mem_stage_ctrl #(.TIMEOUT(2),  .CNT_W(4))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic        o_req[2], o_we[2], o_stall[2], o_bub[2], o_to[2];
  logic [31:0] o_rdata[2];
  logic [15:0] o_cnt[2];

  assign o_req[0]   = bus0.dmem_req_o;   assign o_req[1]   = bus1.dmem_req_o;
  assign o_we[0]    = bus0.dmem_we_o;    assign o_we[1]    = bus1.dmem_we_o;
  assign o_stall[0] = bus0.stall_o;      assign o_stall[1] = bus1.stall_o;
  assign o_bub[0]   = bus0.wb_bubble_o;  assign o_bub[1]   = bus1.wb_bubble_o;
  assign o_to[0]    = bus0.timeout_o;    assign o_to[1]    = bus1.timeout_o;
  assign o_rdata[0] = bus0.rdata_o;      assign o_rdata[1] = bus1.rdata_o;
  assign o_cnt[0]   = bus0.stall_cnt_o;  assign o_cnt[1]   = {12'b0, bus1.stall_cnt_o};

  int n_checks = 0;
  int n_fail   = 0;

  // Model: an access is "in flight" with an age (0 = request cycle, k = k-th
  // wait); it gives up once age reaches the timeout. One trailing cycle follows.
  int          tmo[2]  = '{15, 2};
  int          cmax[2] = '{65535, 15};
  bit          m_busy[2];
  int          m_age[2];
  int          m_after[2];   // 0 none, 1 completed, 2 aborted
  logic [31:0] m_rdata[2];
  bit          m_to[2];
  int          m_cnt[2];
  bit          e_stall[2];

  task automatic chk(input string tag, input int inst, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s[%0d] got=%h exp=%h", tag, inst, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_busy[i] = 0; m_age[i] = 0; m_after[i] = 0;
      m_rdata[i] = '0; m_to[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic check_outputs();
    bit er, ew, es, eb;
    for (int i = 0; i < 2; i++) begin
      er = 0; ew = 0; es = 0; eb = 0;
      if (!rst) begin
        if (m_after[i] == 2) eb = 1;
        else if (m_after[i] == 0) begin
          if (!m_busy[i]) begin
            es = rd | wr; eb = rd | wr;
          end else begin
            er = 1; es = 1; eb = 1; ew = wr;
          end
        end
      end
      e_stall[i] = es;
      chk("dmem_req", i, 32'(o_req[i]), 32'(er));
      chk("dmem_we", i, 32'(o_we[i]), 32'(ew));
      chk("stall", i, 32'(o_stall[i]), 32'(es));
      chk("wb_bubble", i, 32'(o_bub[i]), 32'(eb));
      chk("rdata", i, o_rdata[i], m_rdata[i]);
      chk("timeout", i, 32'(o_to[i]), 32'(m_to[i]));
      chk("stall_cnt", i, 32'(o_cnt[i]), 32'(m_cnt[i]));
    end
  endtask

  task automatic advance_model();
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      if (e_stall[i] && m_cnt[i] < cmax[i]) m_cnt[i]++;
      if (m_after[i] != 0) m_after[i] = 0;
      else if (!m_busy[i]) begin
        if (rd | wr) begin m_busy[i] = 1; m_age[i] = 0; end
      end else if (rdy) begin
        if (rd && !wr) m_rdata[i] = rdat;
        m_busy[i] = 0; m_after[i] = 1;
      end else if (m_age[i] == tmo[i]) begin
        m_busy[i] = 0; m_after[i] = 2; m_to[i] = 1;
      end else m_age[i]++;
    end
  endtask

  task automatic half(input logic r, input logic w, input logic y, input logic [31:0] d, input logic rs);
    rd = r; wr = w; rdy = y; rdat = d; rst = rs;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic tick();
    @(posedge clk);
    advance_model();
    #1;
  endtask

  task automatic cyc(input logic r, input logic w, input logic y, input logic [31:0] d, input logic rs);
    half(r, w, y, d, rs);
    tick();
  endtask

  initial begin
    rst = 1'b1; rd = 1'b0; wr = 1'b0; rdy = 1'b0; rdat = '0;
    @(posedge clk);
    model_reset();
    #1;

    // reset holds outputs low even with an access pending
    cyc(1, 1, 1, 32'h1111_1111, 1);
    cyc(1, 0, 0, 32'h0, 1);

    // load, ready in the request cycle
    cyc(1, 0, 0, 32'h0, 0);
    cyc(1, 0, 1, 32'hDEAD_BEEF, 0);
    half(0, 0, 0, 32'h0, 0);
    chk("ld_done_rdata", 0, o_rdata[0], 32'hDEAD_BEEF);
    chk("ld_done_cnt", 0, 32'(o_cnt[0]), 32'd2);
    chk("ld_done_stall", 0, 32'(o_stall[0]), 32'd0);
    tick();

    // back-to-back loads: next load waits through the done cycle
    cyc(1, 0, 0, 32'h0, 0);
    cyc(1, 0, 1, 32'h1234_5678, 0);
    half(1, 0, 1, 32'h0BAD_0BAD, 0);
    chk("b2b_done_stall", 0, 32'(o_stall[0]), 32'd0);
    chk("b2b_done_req", 0, 32'(o_req[0]), 32'd0);
    tick();
    half(1, 0, 0, 32'h0, 0);
    chk("b2b_detect", 0, 32'(o_stall[0]), 32'd1);
    tick();
    cyc(1, 0, 1, 32'hCAFE_F00D, 0);
    cyc(0, 0, 0, 32'h0, 0);

    // store, ready on the 4th wait cycle
    cyc(0, 1, 0, 32'h0, 0);
    for (int k = 0; k < 4; k++) begin
      half(0, 1, 0, 32'h0, 0);
      chk("st_we", 0, 32'(o_we[0]), 32'd1);
      tick();
    end
    half(0, 1, 1, 32'hFFFF_FFFF, 0);
    chk("st_we_last", 0, 32'(o_we[0]), 32'd1);
    tick();
    half(0, 0, 0, 32'h0, 0);
    chk("st_rdata_kept", 0, o_rdata[0], 32'hCAFE_F00D);
    chk("st_cnt", 0, 32'(o_cnt[0]), 32'd12);
    tick();

    cyc(0, 0, 0, 32'h0, 1);

    // ready coincides with the final permitted wait
    cyc(1, 0, 0, 32'h0, 0);
    for (int k = 0; k < 15; k++) cyc(1, 0, 0, 32'h0, 0);
    cyc(1, 0, 1, 32'hA5A5_A5A5, 0);
    half(0, 0, 0, 32'h0, 0);
    chk("edge_timeout", 0, 32'(o_to[0]), 32'd0);
    chk("edge_rdata", 0, o_rdata[0], 32'hA5A5_A5A5);
    chk("edge_cnt", 0, 32'(o_cnt[0]), 32'd17);
    tick();

    // load never answered: abort
    cyc(1, 0, 0, 32'h0, 0);
    for (int k = 0; k < 16; k++) begin
      half(1, 0, 0, 32'h0, 0);
      chk("to_req_held", 0, 32'(o_req[0]), 32'd1);
      tick();
    end
    half(0, 0, 0, 32'h0, 0);
    chk("err_req", 0, 32'(o_req[0]), 32'd0);
    chk("err_bubble", 0, 32'(o_bub[0]), 32'd1);
    chk("err_timeout", 0, 32'(o_to[0]), 32'd1);
    chk("err_cnt", 0, 32'(o_cnt[0]), 32'd34);
    tick();
    cyc(0, 0, 0, 32'h0, 0);
    half(1, 0, 1, 32'h0, 0);
    chk("to_sticky", 0, 32'(o_to[0]), 32'd1);
    tick();

    // reset while waiting
    cyc(1, 0, 0, 32'h0, 0);
    cyc(1, 0, 0, 32'h0, 0);
    cyc(1, 0, 0, 32'h0, 0);
    half(1, 0, 0, 32'h0, 1);
    chk("rstw_req", 0, 32'(o_req[0]), 32'd0);
    tick();
    half(0, 0, 0, 32'h0, 0);
    chk("rstw_stall", 0, 32'(o_stall[0]), 32'd0);
    chk("rstw_cnt", 0, 32'(o_cnt[0]), 32'd0);
    chk("rstw_to", 0, 32'(o_to[0]), 32'd0);
    tick();

    // random traffic; no reset in the tail so the narrow counter saturates
    for (int n = 0; n < 400; n++) begin
      logic r, w, y, rs;
      r  = ($urandom_range(99) < 45);
      w  = ($urandom_range(99) < 25);
      y  = ($urandom_range(99) < 30);
      rs = (n < 300) && ($urandom_range(63) == 0);
      cyc(r, w, y, $urandom, rs);
    end
    half(0, 0, 0, 32'h0, 0);
    chk("sat_cnt", 1, 32'(o_cnt[1]), 32'hF);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
